// File: rtl/arv_pkg.sv
// -----------------------------------------------------------------------------
// arv_pkg
// Purpose : Core-level types shared by the fetch stages: physical address
//           width, the fetch_1 -> fetch_2 PC bundle, the fetch_2 FSM states
//           and the fetch_2 output-buffer entry.
// Ports   : none (package).
// Config  : ARV_FETCH_2_FAULT_EN adds a fault bit to fetch_2_entry_t.
// -----------------------------------------------------------------------------
package arv_pkg;

    import riscv_pkg::*;

    localparam int unsigned PHY_ADDR_SIZE = 32;

    // PC stream produced by fetch_1.
    typedef struct packed {
        logic [PHY_ADDR_SIZE-1:0] pc;
        logic                     valid;
    } fetch_1_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a PC (and for credit)
        REQ   = 2'd1,   // presenting the read request to memory
        WAIT  = 2'd2,   // request accepted, waiting for the response
        DRAIN = 2'd3    // flushed while a response is owed; swallow it
    } fetch_2_state_e;

    // One buffered instruction as presented to decode.
    typedef struct packed {
        logic [PHY_ADDR_SIZE-1:0] pc;
        logic [ILEN-1:0]          instr;
`ifdef ARV_FETCH_2_FAULT_EN
        logic                     fault;
`endif
    } fetch_2_entry_t;

endpackage : arv_pkg

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Purpose : ISA-level constants shared across the fetch pipeline.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Width of one (uncompressed) instruction word.
    localparam int unsigned ILEN = 32;

endpackage : riscv_pkg

// File: rtl/fetch_2_fifo.sv
// -----------------------------------------------------------------------------
// fetch_2_fifo
// Purpose : Small synchronous FIFO holding fetched {pc, instr} entries.
//           DEPTH must be a power of two so the pointers wrap for free.
//           clear_i empties the FIFO and overrides push/pop in that cycle.
// Ports   :
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         drop all entries
//   push_i          write push_data_i at the tail (ignored when full)
//   push_data_i     entry to write
//   pop_i           retire the head (ignored when empty)
//   head_o          current head entry (undefined contents when empty)
//   count_o         number of valid entries
//   empty_o, full_o occupancy flags
// -----------------------------------------------------------------------------
module fetch_2_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                do_push;
    logic                do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which
    // entries are meaningful, and leaving the array unreset lets it map onto
    // plain registers or LUT RAM without a reset network.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : fetch_2_fifo

// File: rtl/fetch_2.sv
// -----------------------------------------------------------------------------
// fetch_2
// Purpose : Second fetch stage. Accepts PCs from fetch_1, issues at most one
//           outstanding instruction-memory read, and buffers the returned
//           {pc, instr} words in order for decode. A PC is accepted only
//           while the output FIFO has room, so the FIFO cannot overflow.
//           flush_i discards buffered and in-flight work; stall_i only holds
//           the FIFO head.
// Ports   :
//   clk_i, rst_ni          clock, async active-low reset
//   f1_valid_i/f1_pc_i     PC from fetch_1;  f1_ready_o accepts it
//   flush_i, stall_i       pipeline control
//   imem_req_valid_o/addr  read request;     imem_req_ready_i accepts it
//   imem_rsp_valid_i/data  read response
//   out_valid_o/pc/instr   FIFO head presented to decode
// Config  : ARV_FETCH_2_FAULT_EN adds imem_rsp_err_i and out_fault_o;
//           misaligned PCs then produce a fault entry instead of a request.
// -----------------------------------------------------------------------------
module fetch_2
    import riscv_pkg::*;
    import arv_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned ADDR_W    = PHY_ADDR_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              f1_valid_i,
    input  logic [ADDR_W-1:0] f1_pc_i,
    output logic              f1_ready_o,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              imem_req_valid_o,
    output logic [ADDR_W-1:0] imem_req_addr_o,
    input  logic              imem_req_ready_i,
    input  logic              imem_rsp_valid_i,
    input  logic [ILEN-1:0]   imem_rsp_data_i,
`ifdef ARV_FETCH_2_FAULT_EN
    input  logic              imem_rsp_err_i,
    output logic              out_fault_o,
`endif
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [ILEN-1:0]   out_instr_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_1_t       f1_in;
    fetch_2_state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic           fifo_push;
    logic           fifo_pop;
    fetch_2_entry_t fifo_push_data;
    fetch_2_entry_t fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic           fifo_empty;
    logic           fifo_full;

`ifdef ARV_FETCH_2_FAULT_EN
    // A misaligned PC was accepted last cycle; its fault entry is pushed now.
    logic           fault_pend_q, fault_pend_d;
`endif

    assign f1_in.pc    = PHY_ADDR_SIZE'(f1_pc_i);
    assign f1_in.valid = f1_valid_i;

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        f1_ready_o       = 1'b0;
        imem_req_valid_o = 1'b0;
        fifo_push        = 1'b0;
        fifo_push_data   = '0;
`ifdef ARV_FETCH_2_FAULT_EN
        fault_pend_d     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef ARV_FETCH_2_FAULT_EN
                if (fault_pend_q && !flush_i) begin
                    fifo_push            = 1'b1;
                    fifo_push_data.pc    = PHY_ADDR_SIZE'(pc_q);
                    fifo_push_data.fault = 1'b1;
                end
                f1_ready_o = !flush_i && !fifo_full && !fault_pend_q;
`else
                // Credit: a PC is taken only when its result is sure to fit.
                f1_ready_o = !flush_i && !fifo_full;
`endif
                if (f1_in.valid && f1_ready_o) begin
                    pc_d = ADDR_W'(f1_in.pc);
`ifdef ARV_FETCH_2_FAULT_EN
                    if (f1_in.pc[1:0] != 2'b00) fault_pend_d = 1'b1;
                    else                        state_d      = REQ;
`else
                    state_d = REQ;
`endif
                end
            end

            REQ: begin
                // The request stays up during a flush cycle; if memory takes
                // it anyway, its response is still owed and must be drained.
                imem_req_valid_o = 1'b1;
                if (flush_i)               state_d = imem_req_ready_i ? DRAIN : IDLE;
                else if (imem_req_ready_i) state_d = WAIT;
            end

            WAIT: begin
                if (imem_rsp_valid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        fifo_push            = 1'b1;
                        fifo_push_data.pc    = PHY_ADDR_SIZE'(pc_q);
`ifdef ARV_FETCH_2_FAULT_EN
                        fifo_push_data.instr = imem_rsp_err_i ? '0 : imem_rsp_data_i;
                        fifo_push_data.fault = imem_rsp_err_i;
`else
                        fifo_push_data.instr = imem_rsp_data_i;
`endif
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (imem_rsp_valid_i) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

`ifdef ARV_FETCH_2_FAULT_EN
    // Misaligned PCs never reach REQ, so the latched PC is already the address.
    assign imem_req_addr_o = pc_q;
`else
    assign imem_req_addr_o = {pc_q[ADDR_W-1:2], 2'b00};
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pc_q         <= '0;
`ifdef ARV_FETCH_2_FAULT_EN
            fault_pend_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
`ifdef ARV_FETCH_2_FAULT_EN
            fault_pend_q <= fault_pend_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Output buffer
    // ---------------------------------------------------------------------
    assign fifo_pop = out_valid_o && !stall_i;

    fetch_2_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (fetch_2_entry_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (flush_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Head fields are masked while empty so the unreset storage never shows.
    assign out_valid_o = !fifo_empty;
    assign out_pc_o    = fifo_empty ? '0 : ADDR_W'(fifo_head.pc);
    assign out_instr_o = fifo_empty ? '0 : fifo_head.instr;
`ifdef ARV_FETCH_2_FAULT_EN
    assign out_fault_o = fifo_empty ? 1'b0 : fifo_head.fault;
`endif

    // Occupancy is fully captured by the full flag at this level.
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule : fetch_2
